// File: rtl/eth_types_pkg.sv
// Shared Ethernet constants and the transmit framer state type, used by the
// TX framer and reusable by the receive-side parser.
package eth_types_pkg;

   localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
   localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IPG
   } eth_tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32; purely combinational so the
// same block serves the TX FCS generator and the RX FCS check.
module eth_crc32_byte
   import eth_types_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   always_comb begin
      // NOTE: blocking assignments chain the eight bit steps within one evaluation.
      w_c = i_crc ^ {24'h000000, i_data};
      for (int i = 0; i < 8; i++) begin
         w_c = w_c[0] ? ((w_c >> 1) ^ ETH_CRC_POLY) : (w_c >> 1);
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/eth_tx_framer.sv
// RMII transmit framer: preamble, SFD, payload, CRC-32 FCS and IPG on 2-bit pins.
// Define ETH_TX_PAD_EN to zero-pad short frames to MIN_FRAME_BYTES before the FCS.
module eth_tx_framer
   import eth_types_pkg::*;
#(
   parameter int IPG_CYCLES      = 48,
   parameter int MIN_FRAME_BYTES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       tx_en,
   output logic       tx0,
   output logic       tx1,
   output logic       tx_busy,
   output logic       frame_done,
   output logic       tx_underrun
);

   localparam int          IPG_W   = $clog2(IPG_CYCLES + 1);
   localparam logic [10:0] LEN_MAX = 11'h7FF;

   eth_tx_state_t    r_state, w_state_nxt;
   logic [1:0]       r_dibit, w_dibit_nxt;
   logic [7:0]       r_byte, w_byte_nxt;
   logic [2:0]       r_bcnt, w_bcnt_nxt;
   logic [10:0]      r_len, w_len_nxt, w_len_inc;
   logic [IPG_W-1:0] r_ipg, w_ipg_nxt;
   logic [31:0]      r_crc, w_crc_nxt, r_fcs, w_fcs_nxt, w_crc_data;
   logic             r_last_seen, w_last_seen_nxt;
   logic             w_underrun_nxt, w_start, w_fcs_load, w_fcs_bad;
   logic             w_accept, w_stall, w_byte_end, w_tx_en_nxt;
   logic             r_tx_ready, r_tx_en, r_tx0, r_tx1, r_busy, r_done, r_underrun;

   eth_crc32_byte u_crc_data (.i_crc(r_crc), .i_data(tx_data), .o_crc(w_crc_data));

`ifdef ETH_TX_PAD_EN
   logic [31:0] w_crc_zero;
   logic        w_need_pad;
   eth_crc32_byte u_crc_zero (.i_crc(r_crc), .i_data(8'h00), .o_crc(w_crc_zero));
   assign w_need_pad = (r_len < 11'(MIN_FRAME_BYTES));
`else
   logic w_unused_pad_cfg;
   assign w_unused_pad_cfg = ^MIN_FRAME_BYTES;
`endif

   assign w_accept   = r_tx_ready & tx_valid;
   assign w_stall    = r_tx_ready & ~tx_valid;
   assign w_byte_end = (r_dibit == 2'd3);
   assign w_len_inc  = (r_len == LEN_MAX) ? r_len : r_len + 11'd1;

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      w_state_nxt     = r_state;
      w_dibit_nxt     = r_dibit + 2'd1;
      w_byte_nxt      = r_byte;
      w_bcnt_nxt      = r_bcnt;
      w_len_nxt       = r_len;
      w_ipg_nxt       = r_ipg;
      w_crc_nxt       = r_crc;
      w_fcs_nxt       = r_fcs;
      w_last_seen_nxt = r_last_seen;
      w_underrun_nxt  = 1'b0;
      w_start         = 1'b0;
      w_fcs_load      = 1'b0;
      w_fcs_bad       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_dibit_nxt = 2'd0;
            w_start     = tx_valid;
         end
         ST_PREAMBLE: if (w_byte_end) begin
            if (r_bcnt == 3'd6) begin
               w_state_nxt = ST_SFD;
               w_byte_nxt  = ETH_SFD_BYTE;
            end else begin
               w_bcnt_nxt  = r_bcnt + 3'd1;
            end
         end
         ST_SFD, ST_DATA: if (w_byte_end) begin
            if (w_accept) begin
               w_state_nxt     = ST_DATA;
               w_byte_nxt      = tx_data;
               w_crc_nxt       = w_crc_data;
               w_len_nxt       = w_len_inc;
               w_last_seen_nxt = tx_last;
            end else if (w_stall) begin
               w_underrun_nxt = 1'b1;
               w_fcs_load     = 1'b1;
               w_fcs_bad      = 1'b1;
`ifdef ETH_TX_PAD_EN
            end else if (w_need_pad) begin
               w_state_nxt = ST_PAD;
               w_byte_nxt  = 8'h00;
               w_crc_nxt   = w_crc_zero;
               w_len_nxt   = w_len_inc;
`endif
            end else begin
               w_fcs_load = 1'b1;
            end
         end
         ST_PAD: if (w_byte_end) begin
`ifdef ETH_TX_PAD_EN
            if (w_need_pad) begin
               w_byte_nxt = 8'h00;
               w_crc_nxt  = w_crc_zero;
               w_len_nxt  = w_len_inc;
            end else begin
               w_fcs_load = 1'b1;
            end
`else
            w_fcs_load = 1'b1;
`endif
         end
         ST_FCS: if (w_byte_end) begin
            if (r_bcnt == 3'd3) begin
               w_state_nxt = ST_IPG;
               w_ipg_nxt   = '0;
            end else begin
               w_bcnt_nxt  = r_bcnt + 3'd1;
               w_fcs_nxt   = r_fcs >> 8;
               w_byte_nxt  = r_fcs[15:8];
            end
         end
         ST_IPG: begin
            w_dibit_nxt = 2'd0;
            w_ipg_nxt   = r_ipg + IPG_W'(1);
            // The last gap clock is where a waiting frame is first seen, so
            // back-to-back frames are separated by exactly IPG_CYCLES idle clocks.
            if (r_ipg == IPG_W'(IPG_CYCLES - 1)) begin
               w_state_nxt = ST_IDLE;
               w_start     = tx_valid;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_start) begin
         w_state_nxt     = ST_PREAMBLE;
         w_dibit_nxt     = 2'd0;
         w_byte_nxt      = ETH_PREAMBLE_BYTE;
         w_bcnt_nxt      = 3'd0;
         w_len_nxt       = 11'd0;
         w_crc_nxt       = ETH_CRC_INIT;
         w_last_seen_nxt = 1'b0;
      end
      // An underrun sends the raw register, the complement of the valid FCS.
      if (w_fcs_load) begin
         w_state_nxt = ST_FCS;
         w_bcnt_nxt  = 3'd0;
         w_fcs_nxt   = w_fcs_bad ? w_crc_nxt : ~w_crc_nxt;
         w_byte_nxt  = w_fcs_nxt[7:0];
      end
   end

   assign w_tx_en_nxt = (w_state_nxt inside {ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_dibit     <= 2'd0;
         r_byte      <= 8'h00;
         r_bcnt      <= 3'd0;
         r_len       <= 11'd0;
         r_ipg       <= '0;
         r_crc       <= ETH_CRC_INIT;
         r_fcs       <= 32'h0;
         r_last_seen <= 1'b0;
         r_tx_ready  <= 1'b0;
         r_tx_en     <= 1'b0;
         r_tx0       <= 1'b0;
         r_tx1       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_dibit     <= w_dibit_nxt;
         r_byte      <= w_byte_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_len       <= w_len_nxt;
         r_ipg       <= w_ipg_nxt;
         r_crc       <= w_crc_nxt;
         r_fcs       <= w_fcs_nxt;
         r_last_seen <= w_last_seen_nxt;
         r_tx_ready  <= (w_state_nxt == ST_SFD || w_state_nxt == ST_DATA) &&
                        (w_dibit_nxt == 2'd3) && !w_last_seen_nxt;
         r_tx_en     <= w_tx_en_nxt;
         r_tx0       <= w_tx_en_nxt & w_byte_nxt[{w_dibit_nxt, 1'b0}];
         r_tx1       <= w_tx_en_nxt & w_byte_nxt[{w_dibit_nxt, 1'b1}];
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_done      <= (w_state_nxt == ST_FCS) && (w_bcnt_nxt == 3'd3) && (w_dibit_nxt == 2'd3);
         r_underrun  <= w_underrun_nxt;
      end
   end

   assign tx_ready    = r_tx_ready;
   assign tx_en       = r_tx_en;
   assign tx0         = r_tx0;
   assign tx1         = r_tx1;
   assign tx_busy     = r_busy;
   assign frame_done  = r_done;
   assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: a pin monitor rebuilds bytes from the RMII
// dibits and each scenario task compares them with hand-built frames.
`timescale 1ns/1ps
module tb_eth_tx_framer;

   localparam int PERIOD = 20;
   localparam logic [31:0] POLY = 32'hEDB88320;
`ifdef ETH_TX_PAD_EN
   localparam int PAD_TO      = 60;
   localparam int CRC_VEC_CYC = 288;
   localparam int SHORT_CYC   = 288;
`else
   localparam int PAD_TO      = 0;
   localparam int CRC_VEC_CYC = 84;
   localparam int SHORT_CYC   = 52;
`endif

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready, tx_en, tx0, tx1, tx_busy, frame_done, tx_underrun;

   always #(PERIOD / 2) clk = ~clk;

   eth_tx_framer #(.IPG_CYCLES(48), .MIN_FRAME_BYTES(60)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .tx_en(tx_en), .tx0(tx0), .tx1(tx1), .tx_busy(tx_busy),
      .frame_done(frame_done), .tx_underrun(tx_underrun)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Pin monitor, sampled on the falling edge away from the active edge.
   logic [7:0] mon_shift = 8'h00;
   logic       mon_prev_en = 1'b0;
   int         mon_dib = 0, mon_en_cycles = 0, mon_done_at = -1, mon_done_cnt = 0;
   int         mon_ur_cnt = 0, mon_low_run = 0, mon_gap = -1, mon_frames = 0;
   time        mon_rise_t = 0;
   byte_q_t    mon_bytes;

   always @(negedge clk) begin
      if (reset) begin
         mon_prev_en = 1'b0;
         mon_low_run = 0;
      end else begin
         if (tx_en && !mon_prev_en) begin
            mon_gap = mon_low_run;
            mon_dib = 0;
            mon_en_cycles = 0;
            mon_done_cnt = 0;
            mon_done_at = -1;
            mon_ur_cnt = 0;
            mon_bytes.delete();
            mon_rise_t = $time;
         end
         if (!tx_en && mon_prev_en) mon_frames++;
         if (tx_en) begin
            mon_en_cycles++;
            mon_low_run = 0;
            mon_shift = {tx1, tx0, mon_shift[7:2]};
            if (mon_dib == 3) begin
               mon_bytes.push_back(mon_shift);
               mon_dib = 0;
            end else begin
               mon_dib++;
            end
         end else begin
            mon_low_run++;
         end
         if (frame_done) begin
            mon_done_cnt++;
            mon_done_at = mon_en_cycles;
         end
         if (tx_underrun) mon_ur_cnt++;
         mon_prev_en = tx_en;
      end
   end

   function automatic logic [31:0] sw_crc(input byte_q_t d);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < d.size(); i++) begin
         for (int j = 0; j < 8; j++) begin
            logic b = d[i][j] ^ c[0];
            c = c >> 1;
            if (b) c = c ^ POLY;
         end
      end
      return c;
   endfunction

   function automatic byte_q_t build_frame(input byte_q_t pl, input int pad_to, input bit bad);
      byte_q_t f;
      byte_q_t body = pl;
      logic [31:0] c, fcs;
      while (body.size() < pad_to) body.push_back(8'h00);
      c = sw_crc(body);
      fcs = bad ? c : ~c;
      for (int i = 0; i < 7; i++) f.push_back(8'h55);
      f.push_back(8'hD5);
      for (int i = 0; i < body.size(); i++) f.push_back(body[i]);
      for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
      return f;
   endfunction

   function automatic int first_diff(input byte_q_t a, input byte_q_t b);
      int n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   function automatic logic [7:0] qget(input byte_q_t q, input int i);
      return (i >= 0 && i < q.size()) ? q[i] : 8'hxx;
   endfunction

   task automatic send_bytes(input byte_q_t d, input int n_send, output bit ok);
      int t;
      ok = 1'b1;
      for (int i = 0; i < n_send; i++) begin
         tx_data = d[i];
         tx_valid = 1'b1;
         tx_last = (i == d.size() - 1);
         t = 0;
         while (!tx_ready && t < 400) begin
            @(negedge clk);
            t++;
         end
         if (!tx_ready) begin
            ok = 1'b0;
            break;
         end
         @(negedge clk);
      end
      tx_valid = 1'b0;
      tx_last = 1'b0;
      tx_data = 8'h00;
   endtask

   task automatic wait_frames(input int target, output bit ok);
      int t = 0;
      while (mon_frames < target && t < 20000) begin
         @(negedge clk);
         t++;
      end
      ok = (mon_frames >= target);
   endtask

   function automatic byte_q_t crc_vec_expected();
      byte_q_t e;
      byte_q_t pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      if (PAD_TO == 0)
         e = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
               8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
      else
         e = build_frame(pl, PAD_TO, 1'b0);
      return e;
   endfunction

   task automatic test_reset();
      logic [6:0] outs;
      reset = 1'b1;
      tx_valid = 1'b1;
      repeat (3) @(negedge clk);
      n_assert++; if (tx_en !== 1'b0)       begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
      n_assert++; if (tx0 !== 1'b0)         begin n_fail++; $display("FAIL reset_tx0: got %b want 0", tx0); end
      n_assert++; if (tx1 !== 1'b0)         begin n_fail++; $display("FAIL reset_tx1: got %b want 0", tx1); end
      n_assert++; if (tx_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
      n_assert++; if (tx_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
      n_assert++; if (frame_done !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      n_assert++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_tx_underrun: got %b want 0", tx_underrun); end
      tx_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      outs = {tx_en, tx0, tx1, tx_ready, tx_busy, frame_done, tx_underrun};
      n_assert++; if (outs !== 7'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b want 0000000", outs); end
   endtask

   task automatic test_crc_vector();
      byte_q_t pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      byte_q_t exp = crc_vec_expected();
      int start = mon_frames;
      int idx;
      time t0 = $time;
      bit ok;
      send_bytes(pl, pl.size(), ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL crc_vec_ready_timeout: got no tx_ready want handshake"); end
      wait_frames(start + 1, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL crc_vec_end_timeout: got tx_en stuck want frame end"); end
      n_assert++; if (mon_rise_t - t0 !== PERIOD) begin n_fail++; $display("FAIL crc_vec_en_latency: got %0t want %0d", mon_rise_t - t0, PERIOD); end
      idx = first_diff(mon_bytes, exp);
      n_assert++; if (idx >= 0) begin n_fail++; $display("FAIL crc_vec_bytes: byte %0d got %h want %h (len %0d want %0d)", idx, qget(mon_bytes, idx), qget(exp, idx), mon_bytes.size(), exp.size()); end
      n_assert++; if (mon_en_cycles !== CRC_VEC_CYC) begin n_fail++; $display("FAIL crc_vec_en_cycles: got %0d want %0d", mon_en_cycles, CRC_VEC_CYC); end
      n_assert++; if (mon_done_at !== CRC_VEC_CYC || mon_done_cnt !== 1) begin n_fail++; $display("FAIL crc_vec_frame_done: got cycle %0d count %0d want cycle %0d count 1", mon_done_at, mon_done_cnt, CRC_VEC_CYC); end
      n_assert++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL crc_vec_busy_in_ipg: got %b want 1", tx_busy); end
      repeat (60) @(negedge clk);
      n_assert++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL crc_vec_busy_after_ipg: got %b want 0", tx_busy); end
   endtask

   task automatic test_padding();
      byte_q_t pl = '{8'hAB};
      byte_q_t exp = build_frame(pl, PAD_TO, 1'b0);
      int start = mon_frames;
      int idx;
      bit ok;
      send_bytes(pl, 1, ok);
      wait_frames(start + 1, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL pad_timeout: got no frame end want frame end"); end
      idx = first_diff(mon_bytes, exp);
      n_assert++; if (idx >= 0) begin n_fail++; $display("FAIL pad_bytes: byte %0d got %h want %h (len %0d want %0d)", idx, qget(mon_bytes, idx), qget(exp, idx), mon_bytes.size(), exp.size()); end
      n_assert++; if (mon_en_cycles !== SHORT_CYC) begin n_fail++; $display("FAIL pad_en_cycles: got %0d want %0d", mon_en_cycles, SHORT_CYC); end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      byte_q_t a = '{8'h01, 8'h02, 8'h03};
      byte_q_t b = '{8'hA0, 8'hB1};
      byte_q_t exp = build_frame(b, PAD_TO, 1'b0);
      int start = mon_frames;
      int idx;
      bit ok_a, ok_b, ok;
      send_bytes(a, a.size(), ok_a);
      send_bytes(b, b.size(), ok_b);
      n_assert++; if (!(ok_a && ok_b)) begin n_fail++; $display("FAIL b2b_ready_timeout: got %b%b want 11", ok_a, ok_b); end
      wait_frames(start + 2, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL b2b_end_timeout: got %0d frames want %0d", mon_frames - start, 2); end
      n_assert++; if (mon_gap !== 48) begin n_fail++; $display("FAIL b2b_gap: got %0d want 48", mon_gap); end
      idx = first_diff(mon_bytes, exp);
      n_assert++; if (idx >= 0) begin n_fail++; $display("FAIL b2b_second_bytes: byte %0d got %h want %h", idx, qget(mon_bytes, idx), qget(exp, idx)); end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_underrun();
      byte_q_t pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
      byte_q_t sent = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      byte_q_t exp = build_frame(sent, 0, 1'b1);
      int start = mon_frames;
      int idx;
      bit ok;
      send_bytes(pl, 5, ok);
      wait_frames(start + 1, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL ur_timeout: got no frame end want frame end"); end
      n_assert++; if (mon_ur_cnt !== 1) begin n_fail++; $display("FAIL ur_pulses: got %0d want 1", mon_ur_cnt); end
      idx = first_diff(mon_bytes, exp);
      n_assert++; if (idx >= 0) begin n_fail++; $display("FAIL ur_bytes: byte %0d got %h want %h (len %0d want %0d)", idx, qget(mon_bytes, idx), qget(exp, idx), mon_bytes.size(), exp.size()); end
      n_assert++; if (mon_en_cycles !== 68) begin n_fail++; $display("FAIL ur_en_cycles: got %0d want 68", mon_en_cycles); end
      repeat (40) @(negedge clk);
      n_assert++; if ({tx_en, tx_busy} !== 2'b01) begin n_fail++; $display("FAIL ur_ipg: got en/busy %b want 01", {tx_en, tx_busy}); end
      repeat (20) @(negedge clk);
      n_assert++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL ur_ipg_end: got busy %b want 0", tx_busy); end
   endtask

   task automatic test_reset_mid();
      byte_q_t pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      byte_q_t exp = crc_vec_expected();
      logic [6:0] outs;
      int acc = 0, t = 0, start, idx;
      bit ok;
      tx_data = 8'h77;
      tx_valid = 1'b1;
      tx_last = 1'b0;
      while (acc < 3 && t < 400) begin
         @(negedge clk);
         t++;
         if (tx_ready) acc++;
      end
      n_assert++; if (acc !== 3) begin n_fail++; $display("FAIL rstmid_accepts: got %0d want 3", acc); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tx_valid = 1'b0;
      @(negedge clk);
      outs = {tx_en, tx0, tx1, tx_ready, tx_busy, frame_done, tx_underrun};
      n_assert++; if (outs !== 7'b0) begin n_fail++; $display("FAIL rstmid_outputs: got %b want 0000000", outs); end
      reset = 1'b0;
      @(negedge clk);
      start = mon_frames;
      send_bytes(pl, pl.size(), ok);
      wait_frames(start + 1, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no frame end want frame end"); end
      idx = first_diff(mon_bytes, exp);
      n_assert++; if (idx >= 0) begin n_fail++; $display("FAIL rstmid_fresh_crc: byte %0d got %h want %h", idx, qget(mon_bytes, idx), qget(exp, idx)); end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_saturation();
      byte_q_t pl;
      byte_q_t exp;
      int start = mon_frames;
      int idx;
      bit ok;
      for (int i = 0; i < 2100; i++) pl.push_back(i[7:0]);
      exp = build_frame(pl, PAD_TO, 1'b0);
      send_bytes(pl, pl.size(), ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL sat_ready_timeout: got no tx_ready want handshake"); end
      wait_frames(start + 1, ok);
      n_assert++; if (mon_en_cycles !== 8448) begin n_fail++; $display("FAIL sat_en_cycles: got %0d want 8448", mon_en_cycles); end
      idx = first_diff(mon_bytes, exp);
      n_assert++; if (idx >= 0) begin n_fail++; $display("FAIL sat_bytes: byte %0d got %h want %h (len %0d want %0d)", idx, qget(mon_bytes, idx), qget(exp, idx), mon_bytes.size(), exp.size()); end
      n_assert++; if (mon_done_cnt !== 1) begin n_fail++; $display("FAIL sat_frame_done: got %0d want 1", mon_done_cnt); end
   endtask

   initial begin
      test_reset();
      test_crc_vector();
      test_padding();
      test_back_to_back();
      test_underrun();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
